// File: rtl/alu_exec_if.sv
// Issue/result bus of the integer execute unit.
// The reservation station drives the issue half through the master modport;
// the ALU consumes it and drives the registered result broadcast through the slave modport.
interface alu_exec_if;
    logic        alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_val1;
    logic [31:0] alu_val2;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;
    logic [3:0]  alu_rob_pos;

    logic        result;
    logic [3:0]  result_rob_pos;
    logic [31:0] result_val;
    logic        result_jump;
    logic [31:0] result_pc;

    modport master (
        output alu_en, alu_opcode, alu_funct3, alu_funct7,
               alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos,
        input  result, result_rob_pos, result_val, result_jump, result_pc
    );

    modport slave (
        input  alu_en, alu_opcode, alu_funct3, alu_funct7,
               alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos,
        output result, result_rob_pos, result_val, result_jump, result_pc
    );
endinterface

// File: rtl/alu_exec.sv
// Single-issue RV32I integer execute unit with a one-cycle registered result broadcast.
// Optional feature macro: ALU_PERF_CNT_EN adds executed / branch / taken-branch counters.
module alu_exec (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic       rollback,
    alu_exec_if.slave  bus
`ifdef ALU_PERF_CNT_EN
    ,
    output logic [31:0] perf_exec_cnt,
    output logic [31:0] perf_br_cnt,
    output logic [31:0] perf_br_taken_cnt
`endif
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [31:0] op2;
    logic [4:0]  shamt;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus_imm;
    logic        br_cond;
    logic [31:0] exec_val;
    logic        exec_jump;
    logic [31:0] exec_pc;

    logic        result_q,         result_d;
    logic [3:0]  result_rob_pos_q, result_rob_pos_d;
    logic [31:0] result_val_q,     result_val_d;
    logic        result_jump_q,    result_jump_d;
    logic [31:0] result_pc_q,      result_pc_d;

    // Decode and compute the result, control outcome and next PC of the presented instruction
    always_comb begin
        op2         = (bus.alu_opcode == OPC_OP) ? bus.alu_val2 : bus.alu_imm;
        shamt       = op2[4:0];
        pc_plus4    = bus.alu_pc + 32'd4;
        pc_plus_imm = bus.alu_pc + bus.alu_imm;
        br_cond     = 1'b0;
        exec_val    = 32'd0;
        exec_jump   = 1'b0;
        exec_pc     = pc_plus4;
        case (bus.alu_opcode)
            OPC_OP, OPC_OP_IMM: begin
                case (bus.alu_funct3)
                    3'b000: exec_val = (bus.alu_opcode == OPC_OP && bus.alu_funct7)
                                       ? bus.alu_val1 - op2 : bus.alu_val1 + op2;
                    3'b001: exec_val = bus.alu_val1 << shamt;
                    3'b010: exec_val = {31'd0, $signed(bus.alu_val1) < $signed(op2)};
                    3'b011: exec_val = {31'd0, bus.alu_val1 < op2};
                    3'b100: exec_val = bus.alu_val1 ^ op2;
                    3'b101: exec_val = bus.alu_funct7 ? 32'($signed(bus.alu_val1) >>> shamt)
                                                      : bus.alu_val1 >> shamt;
                    3'b110: exec_val = bus.alu_val1 | op2;
                    default: exec_val = bus.alu_val1 & op2;
                endcase
            end
            OPC_LUI:   exec_val = bus.alu_imm;
            OPC_AUIPC: exec_val = pc_plus_imm;
            OPC_JAL: begin
                exec_val  = pc_plus4;
                exec_jump = 1'b1;
                exec_pc   = pc_plus_imm;
            end
            OPC_JALR: begin
                exec_val  = pc_plus4;
                exec_jump = 1'b1;
                exec_pc   = (bus.alu_val1 + bus.alu_imm) & 32'hFFFF_FFFE;
            end
            OPC_BRANCH: begin
                case (bus.alu_funct3)
                    3'b000:  br_cond = (bus.alu_val1 == bus.alu_val2);
                    3'b001:  br_cond = (bus.alu_val1 != bus.alu_val2);
                    3'b100:  br_cond = ($signed(bus.alu_val1) <  $signed(bus.alu_val2));
                    3'b101:  br_cond = ($signed(bus.alu_val1) >= $signed(bus.alu_val2));
                    3'b110:  br_cond = (bus.alu_val1 <  bus.alu_val2);
                    3'b111:  br_cond = (bus.alu_val1 >= bus.alu_val2);
                    default: br_cond = 1'b0;
                endcase
                exec_jump = br_cond;
                exec_pc   = br_cond ? pc_plus_imm : pc_plus4;
            end
            default: ;
        endcase
    end

    // Next broadcast state: freeze when not ready, squash on rollback, otherwise capture
    always_comb begin
        result_d         = result_q;
        result_rob_pos_d = result_rob_pos_q;
        result_val_d     = result_val_q;
        result_jump_d    = result_jump_q;
        result_pc_d      = result_pc_q;
        if (rollback) begin
            result_d = 1'b0;
        end else if (rdy) begin
            result_d = bus.alu_en;
            if (bus.alu_en) begin
                result_rob_pos_d = bus.alu_rob_pos;
                result_val_d     = exec_val;
                result_jump_d    = exec_jump;
                result_pc_d      = exec_pc;
            end
        end
    end

    // Result broadcast registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q         <= 1'b0;
            result_rob_pos_q <= 4'd0;
            result_val_q     <= 32'd0;
            result_jump_q    <= 1'b0;
            result_pc_q      <= 32'd0;
        end else begin
            result_q         <= result_d;
            result_rob_pos_q <= result_rob_pos_d;
            result_val_q     <= result_val_d;
            result_jump_q    <= result_jump_d;
            result_pc_q      <= result_pc_d;
        end
    end

    assign bus.result         = result_q;
    assign bus.result_rob_pos = result_rob_pos_q;
    assign bus.result_val     = result_val_q;
    assign bus.result_jump    = result_jump_q;
    assign bus.result_pc      = result_pc_q;

`ifdef ALU_PERF_CNT_EN
    logic        accept;
    logic        is_branch;
    logic [31:0] perf_exec_cnt_q,     perf_exec_cnt_d;
    logic [31:0] perf_br_cnt_q,       perf_br_cnt_d;
    logic [31:0] perf_br_taken_cnt_q, perf_br_taken_cnt_d;

    // Count accepted instructions; rollback drops the op but never clears the counters
    always_comb begin
        accept              = rdy && !rollback && bus.alu_en;
        is_branch           = (bus.alu_opcode == OPC_BRANCH);
        perf_exec_cnt_d     = perf_exec_cnt_q;
        perf_br_cnt_d       = perf_br_cnt_q;
        perf_br_taken_cnt_d = perf_br_taken_cnt_q;
        if (accept) begin
            perf_exec_cnt_d = perf_exec_cnt_q + 32'd1;
            if (is_branch) begin
                perf_br_cnt_d = perf_br_cnt_q + 32'd1;
                if (br_cond) begin
                    perf_br_taken_cnt_d = perf_br_taken_cnt_q + 32'd1;
                end
            end
        end
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_exec_cnt_q     <= 32'd0;
            perf_br_cnt_q       <= 32'd0;
            perf_br_taken_cnt_q <= 32'd0;
        end else begin
            perf_exec_cnt_q     <= perf_exec_cnt_d;
            perf_br_cnt_q       <= perf_br_cnt_d;
            perf_br_taken_cnt_q <= perf_br_taken_cnt_d;
        end
    end

    assign perf_exec_cnt     = perf_exec_cnt_q;
    assign perf_br_cnt       = perf_br_cnt_q;
    assign perf_br_taken_cnt = perf_br_taken_cnt_q;
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec; covers ALU ops, branches, jumps,
// rollback, rdy freeze and reset. Counter checks are active with ALU_PERF_CNT_EN.
module tb_alu_exec;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic clk;
    logic rst;
    logic rdy;
    logic rollback;
    int   total;
    int   bad;

    alu_exec_if bus ();

`ifdef ALU_PERF_CNT_EN
    logic [31:0] perf_exec_cnt;
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_br_taken_cnt;
`endif

    alu_exec dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .rollback (rollback),
        .bus      (bus)
`ifdef ALU_PERF_CNT_EN
        ,
        .perf_exec_cnt     (perf_exec_cnt),
        .perf_br_cnt       (perf_br_cnt),
        .perf_br_taken_cnt (perf_br_taken_cnt)
`endif
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one instruction, then advance past the next rising edge
    task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] v1, input logic [31:0] v2,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic [3:0] rob);
        bus.alu_en      = 1'b1;
        bus.alu_opcode  = opc;
        bus.alu_funct3  = f3;
        bus.alu_funct7  = f7;
        bus.alu_val1    = v1;
        bus.alu_val2    = v2;
        bus.alu_imm     = imm;
        bus.alu_pc      = pc;
        bus.alu_rob_pos = rob;
        @(posedge clk);
        #1;
    endtask

    // One cycle with no instruction presented
    task automatic idleStep();
        bus.alu_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Compare the whole broadcast against hand-computed values
    task automatic checkOutput(input string tag, input logic exp_res, input logic [3:0] exp_rob,
                               input logic [31:0] exp_val, input logic exp_jump,
                               input logic [31:0] exp_pc);
        total++;
        assert (bus.result === exp_res) else begin
            bad++;
            $error("[TB] FAIL %s result got=%0h want=%0h", tag, bus.result, exp_res);
        end
        total++;
        assert (bus.result_rob_pos === exp_rob) else begin
            bad++;
            $error("[TB] FAIL %s rob_pos got=%0h want=%0h", tag, bus.result_rob_pos, exp_rob);
        end
        total++;
        assert (bus.result_val === exp_val) else begin
            bad++;
            $error("[TB] FAIL %s val got=%h want=%h", tag, bus.result_val, exp_val);
        end
        total++;
        assert (bus.result_jump === exp_jump) else begin
            bad++;
            $error("[TB] FAIL %s jump got=%0h want=%0h", tag, bus.result_jump, exp_jump);
        end
        total++;
        assert (bus.result_pc === exp_pc) else begin
            bad++;
            $error("[TB] FAIL %s pc got=%h want=%h", tag, bus.result_pc, exp_pc);
        end
    endtask

    // Only the valid flag matters when the data fields may be stale
    task automatic checkValid(input string tag, input logic exp_res);
        total++;
        assert (bus.result === exp_res) else begin
            bad++;
            $error("[TB] FAIL %s result got=%0h want=%0h", tag, bus.result, exp_res);
        end
    endtask

`ifdef ALU_PERF_CNT_EN
    task automatic checkPerf(input string tag, input logic [31:0] e_exec,
                             input logic [31:0] e_br, input logic [31:0] e_tk);
        total++;
        assert (perf_exec_cnt === e_exec) else begin
            bad++;
            $error("[TB] FAIL %s exec_cnt got=%0d want=%0d", tag, perf_exec_cnt, e_exec);
        end
        total++;
        assert (perf_br_cnt === e_br) else begin
            bad++;
            $error("[TB] FAIL %s br_cnt got=%0d want=%0d", tag, perf_br_cnt, e_br);
        end
        total++;
        assert (perf_br_taken_cnt === e_tk) else begin
            bad++;
            $error("[TB] FAIL %s br_taken_cnt got=%0d want=%0d", tag, perf_br_taken_cnt, e_tk);
        end
    endtask
`endif

    // Directed test sequence
    initial begin
        total           = 0;
        bad             = 0;
        rst             = 1'b1;
        rdy             = 1'b1;
        rollback        = 1'b0;
        bus.alu_en      = 1'b0;
        bus.alu_opcode  = 7'd0;
        bus.alu_funct3  = 3'd0;
        bus.alu_funct7  = 1'b0;
        bus.alu_val1    = 32'd0;
        bus.alu_val2    = 32'd0;
        bus.alu_imm     = 32'd0;
        bus.alu_pc      = 32'd0;
        bus.alu_rob_pos = 4'd0;

        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        rst = 1'b0;

        // Back-to-back arithmetic and logic
        applyStimulus(OPC_OP, 3'b000, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h200, 4'd1);
        checkOutput("add_ovf", 1'b1, 4'd1, 32'h8000_0000, 1'b0, 32'h204);
        applyStimulus(OPC_OP, 3'b000, 1'b1, 32'h0, 32'h1, 32'h0, 32'h204, 4'd2);
        checkOutput("sub_wrap", 1'b1, 4'd2, 32'hFFFF_FFFF, 1'b0, 32'h208);
        applyStimulus(OPC_OP_IMM, 3'b101, 1'b1, 32'h8000_0000, 32'h0, 32'h4, 32'h208, 4'd3);
        checkOutput("srai", 1'b1, 4'd3, 32'hF800_0000, 1'b0, 32'h20C);
        applyStimulus(OPC_OP_IMM, 3'b101, 1'b0, 32'h8000_0000, 32'h0, 32'h4, 32'h20C, 4'd4);
        checkOutput("srli", 1'b1, 4'd4, 32'h0800_0000, 1'b0, 32'h210);
        applyStimulus(OPC_OP, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h210, 4'd5);
        checkOutput("slt", 1'b1, 4'd5, 32'h1, 1'b0, 32'h214);
        applyStimulus(OPC_OP, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h214, 4'd6);
        checkOutput("sltu", 1'b1, 4'd6, 32'h0, 1'b0, 32'h218);
        applyStimulus(OPC_OP_IMM, 3'b000, 1'b1, 32'd10, 32'd99, 32'd5, 32'h218, 4'd7);
        checkOutput("addi_f7", 1'b1, 4'd7, 32'd15, 1'b0, 32'h21C);
        applyStimulus(OPC_OP, 3'b001, 1'b0, 32'h0000_0003, 32'h0000_0024, 32'h0, 32'h21C, 4'd8);
        checkOutput("sll_shamt", 1'b1, 4'd8, 32'h0000_0030, 1'b0, 32'h220);

        // Branches and jumps
        applyStimulus(OPC_BRANCH, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h20, 32'h100, 4'd10);
        checkOutput("blt", 1'b1, 4'd10, 32'h0, 1'b1, 32'h120);
        applyStimulus(OPC_BRANCH, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h20, 32'h100, 4'd11);
        checkOutput("bltu", 1'b1, 4'd11, 32'h0, 1'b0, 32'h104);
        applyStimulus(OPC_JALR, 3'b000, 1'b0, 32'h1001, 32'h0, 32'h2, 32'h40, 4'd9);
        checkOutput("jalr", 1'b1, 4'd9, 32'h44, 1'b1, 32'h1002);
        applyStimulus(OPC_JAL, 3'b000, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h300, 4'd12);
        checkOutput("jal_back", 1'b1, 4'd12, 32'h304, 1'b1, 32'h2F0);
        applyStimulus(OPC_LUI, 3'b000, 1'b0, 32'h0, 32'h0, 32'h1234_5000, 32'h400, 4'd13);
        checkOutput("lui", 1'b1, 4'd13, 32'h1234_5000, 1'b0, 32'h404);
        applyStimulus(OPC_AUIPC, 3'b000, 1'b0, 32'h0, 32'h0, 32'h2000, 32'h1000, 4'd14);
        checkOutput("auipc", 1'b1, 4'd14, 32'h3000, 1'b0, 32'h1004);
        applyStimulus(7'h7F, 3'b000, 1'b0, 32'h5, 32'h6, 32'h7, 32'h600, 4'd15);
        checkOutput("bad_opc", 1'b1, 4'd15, 32'h0, 1'b0, 32'h604);
        applyStimulus(OPC_BRANCH, 3'b010, 1'b0, 32'h5, 32'h5, 32'h40, 32'h700, 4'd0);
        checkOutput("bad_br_f3", 1'b1, 4'd0, 32'h0, 1'b0, 32'h704);

        idleStep();
        checkValid("idle_drop", 1'b0);

        // Rollback squashes the instruction presented in that cycle
        rollback = 1'b1;
        applyStimulus(OPC_OP, 3'b000, 1'b0, 32'h1, 32'h1, 32'h0, 32'h800, 4'd3);
        rollback = 1'b0;
        checkValid("rollback", 1'b0);

        // A result is frozen while rdy is low, even with new instructions offered
        applyStimulus(OPC_OP, 3'b100, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h500, 4'd5);
        checkOutput("xor", 1'b1, 4'd5, 32'hFF00_FF00, 1'b0, 32'h504);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(OPC_JAL, 3'b000, 1'b0, 32'h0, 32'h0, 32'h80, 32'h900 + i, 4'd2);
            checkOutput("rdy_hold", 1'b1, 4'd5, 32'hFF00_FF00, 1'b0, 32'h504);
        end
        rdy = 1'b1;
        idleStep();
        checkValid("rdy_release", 1'b0);

        // Reset in the middle of a stream
        applyStimulus(OPC_OP, 3'b110, 1'b0, 32'hA000_0000, 32'h0000_000A, 32'h0, 32'hA00, 4'd6);
        checkOutput("or", 1'b1, 4'd6, 32'hA000_000A, 1'b0, 32'hA04);
        rst = 1'b1;
        applyStimulus(OPC_OP, 3'b111, 1'b0, 32'hFFFF_FFFF, 32'h0000_00FF, 32'h0, 32'hA04, 4'd7);
        checkOutput("mid_reset", 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
`ifdef ALU_PERF_CNT_EN
        checkPerf("perf_reset0", 32'd0, 32'd0, 32'd0);
`endif
        rst = 1'b0;
        applyStimulus(OPC_OP, 3'b111, 1'b0, 32'hFFFF_FFFF, 32'h0000_00FF, 32'h0, 32'hA04, 4'd7);
        checkOutput("and", 1'b1, 4'd7, 32'h0000_00FF, 1'b0, 32'hA08);

`ifdef ALU_PERF_CNT_EN
        // AND above is op 1; then BEQ taken, BNE not taken, OR; rollback and stalled ops excluded
        applyStimulus(OPC_BRANCH, 3'b000, 1'b0, 32'h5, 32'h5, 32'h10, 32'hB00, 4'd1);
        applyStimulus(OPC_BRANCH, 3'b001, 1'b0, 32'h5, 32'h5, 32'h10, 32'hB04, 4'd2);
        applyStimulus(OPC_OP, 3'b110, 1'b0, 32'h1, 32'h2, 32'h0, 32'hB08, 4'd3);
        rollback = 1'b1;
        applyStimulus(OPC_BRANCH, 3'b000, 1'b0, 32'h1, 32'h1, 32'h10, 32'hB0C, 4'd4);
        rollback = 1'b0;
        rdy = 1'b0;
        applyStimulus(OPC_BRANCH, 3'b000, 1'b0, 32'h1, 32'h1, 32'h10, 32'hB10, 4'd5);
        rdy = 1'b1;
        idleStep();
        checkPerf("perf_counts", 32'd4, 32'd2, 32'd1);
        rollback = 1'b1;
        idleStep();
        rollback = 1'b0;
        checkPerf("perf_rollback_keep", 32'd4, 32'd2, 32'd1);
        rst = 1'b1;
        idleStep();
        rst = 1'b0;
        checkPerf("perf_rst", 32'd0, 32'd0, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Single-issue RV32I integer execute unit sitting directly downstream of the reservation station. It accepts one ready instruction per cycle (operands already resolved), computes the integer result and any control-flow outcome, and drives a registered result broadcast consumed by the RS, LSB and ROB one cycle later. Branch/jump resolution (taken flag and target PC) is produced here for the ROB to check against prediction.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low = freeze all state
- rollback  in  1  ROB flush; discards in-flight result
- alu_en  in  1  instruction valid this cycle
- alu_opcode  in  7  RV32I opcode
- alu_funct3  in  3  funct3
- alu_funct7  in  1  instruction bit 30 (SUB/SRA/SRAI select)
- alu_val1  in  32  rs1 value
- alu_val2  in  32  rs2 value
- alu_imm  in  32  sign-extended immediate (U-type already shifted)
- alu_pc  in  32  instruction PC
- alu_rob_pos  in  4  destination ROB entry
- result  out  1  broadcast valid
- result_rob_pos  out  4  ROB entry of result
- result_val  out  32  writeback value
- result_jump  out  1  control transfer taken
- result_pc  out  32  next PC actually executed
- perf_exec_cnt / perf_br_cnt / perf_br_taken_cnt  out  32 each  (only with ALU_PERF_CNT_EN)

## Operation
- OP (0110011): funct3 000 ADD, or SUB if funct7; 001 SLL; 010 SLT (signed); 011 SLTU; 100 XOR; 101 SRL, or SRA if funct7; 110 OR; 111 AND. Second operand val2.
- OP-IMM (0010011): same table with imm as second operand; funct3 000 always ADD (funct7 ignored); shift amount = operand[4:0] for all shifts.
- LUI: val = imm. AUIPC: val = pc + imm.
- JAL: val = pc+4, jump=1, pc_out = pc+imm.
- JALR: val = pc+4, jump=1, pc_out = (val1+imm) & 32'hFFFF_FFFE.
- BRANCH (1100011): funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE (signed), 110 BLTU, 111 BGEU; jump = condition; pc_out = taken ? pc+imm : pc+4; val = 0.
- Non-control instructions: jump=0, pc_out = pc+4.
- Unrecognised opcode/funct3: result still asserted, val=0, jump=0, pc_out=pc+4 (ROB must always see completion).
- All arithmetic modulo 2^32; no overflow/exception signalling.

## Timing
- Reset values: result=0, result_rob_pos=0, result_val=0, result_jump=0, result_pc=0.
- Latency exactly 1: alu_en sampled at posedge N (rdy=1) -> result=1 with all fields valid after posedge N, for exactly one cycle unless next alu_en follows.
- Back-to-back: alu_en every cycle -> result every cycle, no bubbles, no stall output (throughput 1/cycle).
- alu_en=0 at posedge (rdy=1): result<=0; data fields may hold stale values.
- Priority at posedge: rst > rollback > !rdy > normal.
- rollback=1: result<=0 regardless of alu_en; the instruction presented that cycle is dropped.
- rdy=0: every register, including result, holds its value.
- Reset mid-stream: in-flight result discarded, outputs return to reset values next cycle.

## Configuration
- ALU_PERF_CNT_EN defined: three 32-bit counters and ports exist. On each accepted alu_en (rdy=1, no rst, no rollback): perf_exec_cnt+1; if BRANCH opcode also perf_br_cnt+1; if BRANCH taken also perf_br_taken_cnt+1. Reset to 0 by rst only (not rollback); wrap FFFF_FFFF->0; hold when rdy=0.
- Not defined: counters and perf_* ports absent; behaviour otherwise identical.

## Test plan
- ADD val1=7FFF_FFFF, val2=1 -> next cycle result=1, val=8000_0000, jump=0, pc_out=pc+4; SUB 0-1 -> FFFF_FFFF.
- SRAI val1=8000_0000 imm=4 funct7=1 -> val=F800_0000; SRLI same -> 0800_0000; SLT FFFF_FFFF vs 1 -> 1, SLTU -> 0.
- BLT val1=FFFF_FFFF val2=0 pc=100 imm=20 -> jump=1, pc_out=120; BLTU same -> jump=0, pc_out=104.
- JALR val1=1001 imm=2 pc=40 -> val=44, jump=1, pc_out=1002; alu_rob_pos=9 -> result_rob_pos=9.
- alu_en with rollback=1 -> result=0 next cycle; rdy=0 for 3 cycles after a result -> result held at 1 with same fields, then drops.
- With ALU_PERF_CNT_EN: 5 ops incl. 2 branches (1 taken), one during rollback -> counters 4/2/1 (or 4/1/... per dropped op type, checked exactly); rst -> all 0.
